// File: rtl/mcbsp_rx_param_pkg.sv
// rtl/mcbsp_rx_param_pkg.sv - shared types and constants for the McBSP receiver
// Purpose: state encoding (one-hot), edge-select constants and a clog2 helper
//          used by mcbsp_rx_param and mcbsp_sync_edge.
// Ports:   none (package).
package mcbsp_rx_param_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_WAIT_FS   = 4'b0010,
    ST_SHIFT     = 4'b0100,
    ST_BLOCK_END = 4'b1000
  } state_e;

  // CAPTURE_EDGE parameter values
  localparam int CAP_RISING  = 0;
  localparam int CAP_FALLING = 1;
  // FS_EDGE parameter values
  localparam int FS_FALLING  = 0;
  localparam int FS_RISING   = 1;
  // mcbsp_sync_edge EDGE_SEL values
  localparam int EDGE_RISE   = 0;
  localparam int EDGE_FALL   = 1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mcbsp_sync_edge.sv
// rtl/mcbsp_sync_edge.sv - synchroniser chain with edge detector
// Purpose: brings an asynchronous pin into i_clk through DEPTH flops and flags
//          the selected edge using the last two flops of the chain.
// Ports:   i_clk, i_rst (sync, active low), i_d (async pin),
//          o_level (synchronised level), o_edge (one-cycle edge pulse).
module mcbsp_sync_edge
  import mcbsp_rx_param_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int EDGE_SEL = EDGE_RISE
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_edge
);

  // r_sync[0] is the first (metastable) stage, r_sync[DEPTH-1] the oldest
  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_d};
    end
  end

  assign o_level = r_sync[DEPTH-1];
  assign o_edge  = (EDGE_SEL == EDGE_FALL) ? (r_sync[DEPTH-1] & ~r_sync[DEPTH-2])
                                           : (~r_sync[DEPTH-1] & r_sync[DEPTH-2]);

endmodule

// File: rtl/mcbsp_rx_param.sv
// rtl/mcbsp_rx_param.sv - parametrised McBSP slave serial receiver
// Purpose: samples clkx/fsx/dr in the system clock domain, deserialises
//          DATA_W-bit words (SLOTS per frame sync), counts BLOCK_WORDS per block
//          and hands words out over a valid/ready holding register.
// Ports:   i_clk, i_rst (sync, active low); i_dr, i_fsx, i_clkx (McBSP pins);
//          i_transform_en (receive enable); i_err_clr (clears sticky flags);
//          o_rx_valid/i_rx_ready/o_rx_data/o_rx_slot/o_rx_last (word handshake);
//          o_word_cnt, o_block_done, o_idle (block status);
//          o_overrun, o_sync_err (sticky error flags).
module mcbsp_rx_param
  import mcbsp_rx_param_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int SLOTS        = 1,
  parameter int BLOCK_WORDS  = 721,
  parameter int SYNC_STAGES  = 3,
  parameter int CLK_DLY      = 3,
  parameter int CAPTURE_EDGE = CAP_RISING,
  parameter int FS_EDGE      = FS_FALLING,
  parameter int MSB_FIRST    = 1
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_dr,
  input  logic                                      i_fsx,
  input  logic                                      i_clkx,
  input  logic                                      i_transform_en,
  input  logic                                      i_err_clr,
  output logic                                      o_rx_valid,
  input  logic                                      i_rx_ready,
  output logic [DATA_W-1:0]                         o_rx_data,
  output logic [((SLOTS > 1) ? clog2(SLOTS) : 1)-1:0] o_rx_slot,
  output logic                                      o_rx_last,
  output logic [clog2(BLOCK_WORDS+1)-1:0]           o_word_cnt,
  output logic                                      o_block_done,
  output logic                                      o_idle,
  output logic                                      o_overrun,
  output logic                                      o_sync_err
);

  localparam int BIT_W  = clog2(DATA_W);
  localparam int SLOT_W = (SLOTS > 1) ? clog2(SLOTS) : 1;
  localparam int WCNT_W = clog2(BLOCK_WORDS + 1);

  state_e              r_state, w_state_nxt;
  logic                w_dr, w_dr_edge_unused;
  logic                w_clkx_level_unused, w_cap_edge;
  logic                w_fsx_level_unused, w_fs_edge;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [SLOT_W-1:0]   r_slot_cnt;
  logic [WCNT_W-1:0]   r_word_cnt;
  logic                r_rx_valid, r_rx_last, r_overrun, r_sync_err;
  logic [DATA_W-1:0]   r_rx_data;
  logic [SLOT_W-1:0]   r_rx_slot;
  logic                w_in_shift, w_bit_last, w_slot_last, w_last_word;
  logic                w_resync, w_word_done, w_hold_free;

  mcbsp_sync_edge #(.DEPTH(SYNC_STAGES), .EDGE_SEL(EDGE_RISE)) u_sync_dr (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_dr),
    .o_level(w_dr), .o_edge(w_dr_edge_unused)
  );

  // clkx gets extra taps so dr has settled by the time its capture edge is seen
  mcbsp_sync_edge #(
    .DEPTH(SYNC_STAGES + CLK_DLY),
    .EDGE_SEL((CAPTURE_EDGE == CAP_FALLING) ? EDGE_FALL : EDGE_RISE)
  ) u_sync_clkx (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_clkx),
    .o_level(w_clkx_level_unused), .o_edge(w_cap_edge)
  );

  mcbsp_sync_edge #(
    .DEPTH(SYNC_STAGES),
    .EDGE_SEL((FS_EDGE == FS_RISING) ? EDGE_RISE : EDGE_FALL)
  ) u_sync_fsx (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_fsx),
    .o_level(w_fsx_level_unused), .o_edge(w_fs_edge)
  );

  assign w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], w_dr}
                                        : {w_dr, r_shift[DATA_W-1:1]};

  assign w_in_shift  = (r_state == ST_SHIFT) & i_transform_en;
  assign w_bit_last  = (r_bit_cnt == BIT_W'(DATA_W - 1));
  assign w_slot_last = (r_slot_cnt == SLOT_W'(SLOTS - 1));
  assign w_last_word = (r_word_cnt == WCNT_W'(BLOCK_WORDS - 1));
  // A frame sync in the middle of a word or frame wins over a coincident capture edge
  assign w_resync    = w_in_shift & w_fs_edge & ((r_bit_cnt != '0) | (r_slot_cnt != '0));
  assign w_word_done = w_in_shift & ~w_resync & w_cap_edge & w_bit_last;
  assign w_hold_free = ~r_rx_valid | i_rx_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_idle       = 1'b0;
    o_block_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_idle = 1'b1;
        if (i_transform_en) w_state_nxt = ST_WAIT_FS;
      end
      ST_WAIT_FS: begin
        if (!i_transform_en) w_state_nxt = ST_IDLE;
        else if (w_fs_edge)  w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!i_transform_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_word_done) begin
          if (w_last_word)      w_state_nxt = ST_BLOCK_END;
          else if (w_slot_last) w_state_nxt = ST_WAIT_FS;
        end
      end
      ST_BLOCK_END: begin
        o_block_done = 1'b1;
        w_state_nxt  = i_transform_en ? ST_WAIT_FS : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Deserialiser and counters
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_slot_cnt <= '0;
      r_word_cnt <= '0;
    end else if (!i_transform_en && (r_state != ST_BLOCK_END)) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_slot_cnt <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        ST_WAIT_FS: begin
          if (w_fs_edge) begin
            r_bit_cnt  <= '0;
            r_slot_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_resync) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_slot_cnt <= '0;
          end else if (w_cap_edge) begin
            r_shift <= w_shift_nxt;
            if (w_bit_last) begin
              r_bit_cnt  <= '0;
              r_word_cnt <= r_word_cnt + WCNT_W'(1);
              r_slot_cnt <= w_slot_last ? '0 : r_slot_cnt + SLOT_W'(1);
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end
        ST_BLOCK_END: r_word_cnt <= '0;
        default: ;
      endcase
    end
  end

  // Holding register and sticky flags; both survive a transform_en drop
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_slot  <= '0;
      r_rx_last  <= 1'b0;
      r_overrun  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_word_done && w_hold_free) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= w_shift_nxt;
        r_rx_slot  <= r_slot_cnt;
        r_rx_last  <= w_last_word;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (w_word_done && !w_hold_free) r_overrun <= 1'b1;
      else if (i_err_clr)              r_overrun <= 1'b0;

      if (w_resync)       r_sync_err <= 1'b1;
      else if (i_err_clr) r_sync_err <= 1'b0;
    end
  end

  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
  assign o_rx_slot  = r_rx_slot;
  assign o_rx_last  = r_rx_last;
  assign o_word_cnt = r_word_cnt;
  assign o_overrun  = r_overrun;
  assign o_sync_err = r_sync_err;

endmodule

// File: tb/tb_mcbsp_rx_param.sv
// tb/tb_mcbsp_rx_param.sv - self-checking bench for mcbsp_rx_param
module tb_mcbsp_rx_param;

  localparam int H = 4;  // clk cycles per clkx half period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, dr, fsx, clkx;
  logic en_a, clr_a, rdy_a, en_b, clr_b, rdy_b;

  logic        val_a, last_a, done_a, idle_a, ovr_a, serr_a;
  logic [31:0] data_a;
  logic [0:0]  slot_a;
  logic [2:0]  wcnt_a;

  logic        val_b, last_b, done_b, idle_b, ovr_b, serr_b;
  logic [15:0] data_b;
  logic [1:0]  slot_b;
  logic [3:0]  wcnt_b;

  mcbsp_rx_param #(
    .DATA_W(32), .SLOTS(1), .BLOCK_WORDS(4), .SYNC_STAGES(3), .CLK_DLY(3),
    .CAPTURE_EDGE(0), .FS_EDGE(0), .MSB_FIRST(1)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_dr(dr), .i_fsx(fsx), .i_clkx(clkx),
    .i_transform_en(en_a), .i_err_clr(clr_a),
    .o_rx_valid(val_a), .i_rx_ready(rdy_a), .o_rx_data(data_a),
    .o_rx_slot(slot_a), .o_rx_last(last_a), .o_word_cnt(wcnt_a),
    .o_block_done(done_a), .o_idle(idle_a), .o_overrun(ovr_a), .o_sync_err(serr_a)
  );

  mcbsp_rx_param #(
    .DATA_W(16), .SLOTS(4), .BLOCK_WORDS(8), .SYNC_STAGES(3), .CLK_DLY(3),
    .CAPTURE_EDGE(0), .FS_EDGE(0), .MSB_FIRST(0)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_dr(dr), .i_fsx(fsx), .i_clkx(clkx),
    .i_transform_en(en_b), .i_err_clr(clr_b),
    .o_rx_valid(val_b), .i_rx_ready(rdy_b), .o_rx_data(data_b),
    .o_rx_slot(slot_b), .o_rx_last(last_b), .o_word_cnt(wcnt_b),
    .o_block_done(done_b), .o_idle(idle_b), .o_overrun(ovr_b), .o_sync_err(serr_b)
  );

  typedef struct { logic [63:0] data; int slot; bit last; } rx_t;
  typedef struct { logic [63:0] word; bit last; int wcnt; int done; } vec_a_t;
  typedef struct { logic [63:0] word; int slot; bit last; } vec_b_t;

  rx_t q_a[$];
  rx_t q_b[$];
  rx_t e_a, e_b;
  int  done_a_cnt = 0;
  int  done_b_cnt = 0;
  int  n_vec = 0;
  int  n_err = 0;

  // Accepted words and block_done pulses, sampled on the inactive edge
  always @(negedge clk) begin
    if (val_a && rdy_a) begin
      e_a.data = 64'(data_a); e_a.slot = int'(slot_a); e_a.last = last_a;
      q_a.push_back(e_a);
    end
    if (val_b && rdy_b) begin
      e_b.data = 64'(data_b); e_b.slot = int'(slot_b); e_b.last = last_b;
      q_b.push_back(e_b);
    end
    if (done_a) done_a_cnt++;
    if (done_b) done_b_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // dr changes on the clkx falling edge, captured on the rising edge
  task automatic send_bit(input logic b);
    clkx = 1'b0;
    dr   = b;
    tick(H);
    clkx = 1'b1;
    tick(H);
  endtask

  task automatic send_word(input logic [63:0] w, input int width, input bit msb,
                           input bit fs, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (fs) fsx = (i == 0) ? 1'b0 : 1'b1;
      send_bit(msb ? w[width-1-i] : w[i]);
    end
    fsx = 1'b1;
  endtask

  task automatic gap();
    clkx = 1'b0;
    tick(16);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pop(input bit use_b, input string name, input logic [63:0] exp_d,
                         input int exp_s, input bit exp_l);
    rx_t e;
    bit  got;
    got = 1'b0;
    n_vec++;
    if (use_b) begin
      if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
    end else begin
      if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
    end
    if (!got) begin
      n_err++;
      $display("FAIL %s: no word received, expected data=%0h", name, exp_d);
    end else if (e.data !== exp_d || e.slot != exp_s || e.last !== exp_l) begin
      n_err++;
      $display("FAIL %s: got data=%0h slot=%0d last=%0b, expected data=%0h slot=%0d last=%0b",
               name, e.data, e.slot, e.last, exp_d, exp_s, exp_l);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_a_t va[4];
  vec_b_t vb[8];
  logic [63:0] nb[4];

  initial begin
    va[0] = '{64'hA5A5_0F0F, 1'b0, 1, 0};
    va[1] = '{64'h1234_5678, 1'b0, 2, 0};
    va[2] = '{64'hDEAD_BEEF, 1'b0, 3, 0};
    va[3] = '{64'h0000_0001, 1'b1, 0, 1};
    vb[0] = '{64'h0001, 0, 1'b0};
    vb[1] = '{64'h8000, 1, 1'b0};
    vb[2] = '{64'h1234, 2, 1'b0};
    vb[3] = '{64'hABCD, 3, 1'b0};
    vb[4] = '{64'h1111, 0, 1'b0};
    vb[5] = '{64'h2222, 1, 1'b0};
    vb[6] = '{64'h3333, 2, 1'b0};
    vb[7] = '{64'h4444, 3, 1'b1};
    nb[0] = 64'h0000_0011; nb[1] = 64'h0000_0022;
    nb[2] = 64'h0000_0033; nb[3] = 64'h8000_0044;

    rst = 1'b0; dr = 1'b0; fsx = 1'b1; clkx = 1'b0;
    en_a = 1'b0; clr_a = 1'b0; rdy_a = 1'b1;
    en_b = 1'b0; clr_b = 1'b0; rdy_b = 1'b1;
    tick(4);
    rst = 1'b1;

    // Reset state
    chk("reset rx_valid", val_a, 0);
    chk("reset rx_data", data_a, 0);
    chk("reset rx_last", last_a, 0);
    chk("reset word_cnt", wcnt_a, 0);
    chk("reset block_done", done_a, 0);
    chk("reset idle", idle_a, 1);
    chk("reset overrun", ovr_a, 0);
    chk("reset sync_err", serr_a, 0);
    chk("reset idle_b", idle_b, 1);
    tick(4);

    // Block of four MSB-first 32-bit words, one frame sync each
    en_a = 1'b1;
    tick(2);
    chk("enable leaves idle", idle_a, 0);
    for (int i = 0; i < 4; i++) begin
      send_word(va[i].word, 32, 1'b1, 1'b1, 32);
      gap();
      chk_pop(1'b0, $sformatf("blk_a word%0d", i), va[i].word, 0, va[i].last);
      chk($sformatf("blk_a word_cnt%0d", i), wcnt_a, va[i].wcnt);
      chk($sformatf("blk_a done_cnt%0d", i), done_a_cnt, va[i].done);
    end
    chk("blk_a no extra word", q_a.size(), 0);
    en_a = 1'b0;
    tick(2);

    // LSB-first 16-bit TDM, 4 slots per frame sync, 8-word block
    en_b = 1'b1;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      send_word(vb[i].word, 16, 1'b0, (i % 4) == 0, 16);
      if ((i % 4) == 3) gap();
    end
    send_word(64'h5555, 16, 1'b0, 1'b0, 16);  // no frame sync: must be ignored
    gap();
    for (int i = 0; i < 8; i++)
      chk_pop(1'b1, $sformatf("tdm_b word%0d", i), vb[i].word, vb[i].slot, vb[i].last);
    chk("tdm_b no word without fs", q_b.size(), 0);
    chk("tdm_b done_cnt", done_b_cnt, 1);
    chk("tdm_b word_cnt", wcnt_b, 0);
    chk("tdm_b sync_err", serr_b, 0);
    en_b = 1'b0;

    // Overrun: consumer stalls while two words arrive
    en_a = 1'b1;
    rdy_a = 1'b0;
    tick(2);
    send_word(64'h1111_2222, 32, 1'b1, 1'b1, 32);
    gap();
    send_word(64'h3333_4444, 32, 1'b1, 1'b1, 32);
    gap();
    chk("ovr rx_valid", val_a, 1);
    chk("ovr rx_data held", data_a, 32'h1111_2222);
    chk("ovr overrun set", ovr_a, 1);
    chk("ovr word_cnt", wcnt_a, 2);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    chk("ovr overrun cleared", ovr_a, 0);
    chk("ovr rx_data after clr", data_a, 32'h1111_2222);
    chk("ovr rx_valid after clr", val_a, 1);
    rdy_a = 1'b1;
    tick(1);
    chk("ovr rx_valid consumed", val_a, 0);
    chk_pop(1'b0, "ovr word", 64'h1111_2222, 0, 1'b0);
    chk("ovr no second word", q_a.size(), 0);

    // Frame sync after 10 bits: resync, partial word discarded
    send_word(64'hFFFF_FFFF, 32, 1'b1, 1'b1, 10);
    gap();
    send_word(64'hCAFE_F00D, 32, 1'b1, 1'b1, 32);
    gap();
    chk("sync sync_err set", serr_a, 1);
    chk_pop(1'b0, "sync word after resync", 64'hCAFE_F00D, 0, 1'b0);
    chk("sync no partial word", q_a.size(), 0);
    chk("sync word_cnt", wcnt_a, 3);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    chk("sync sync_err cleared", serr_a, 0);

    // transform_en dropped mid-word
    en_a = 1'b0;
    tick(1);
    chk("drop1 idle", idle_a, 1);
    chk("drop1 word_cnt", wcnt_a, 0);
    en_a = 1'b1;
    tick(2);
    send_word(64'h0BAD_CAFE, 32, 1'b1, 1'b1, 32);
    gap();
    chk("drop2 word_cnt before", wcnt_a, 1);
    send_word(64'h7654_3210, 32, 1'b1, 1'b1, 20);
    tick(6);
    en_a = 1'b0;
    tick(1);
    chk("drop2 idle", idle_a, 1);
    chk("drop2 word_cnt", wcnt_a, 0);
    tick(10);
    chk_pop(1'b0, "drop2 first word", 64'h0BAD_CAFE, 0, 1'b0);
    chk("drop2 no partial word", q_a.size(), 0);
    en_a = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      send_word(nb[i], 32, 1'b1, 1'b1, 32);
      gap();
      chk_pop(1'b0, $sformatf("restart word%0d", i), nb[i], 0, i == 3);
    end
    chk("restart done_cnt", done_a_cnt, 2);
    chk("restart word_cnt", wcnt_a, 0);

    // Reset mid-word with a word parked in the holding register
    rdy_a = 1'b0;
    send_word(64'h5A5A_5A5A, 32, 1'b1, 1'b1, 32);
    gap();
    chk("rst held valid", val_a, 1);
    send_word(64'hFFFF_FFFF, 32, 1'b1, 1'b1, 10);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    chk("rst rx_valid", val_a, 0);
    chk("rst rx_data", data_a, 0);
    chk("rst word_cnt", wcnt_a, 0);
    chk("rst idle", idle_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
